// File: rtl/algo_hash_update_queue.sv
// algo_hash_update_queue
// Coalescing update FIFO that sits in front of the hash-table search/update top.
// Host requests are queued in order. A request whose key is already pending
// overwrites that entry in place rather than allocating a new one.
// Entries are issued one per cycle when the table is ready and not backpressuring.
module algo_hash_update_queue #(
  parameter int KYWIDTH = 32,
  parameter int DTWIDTH = 32,
  parameter int QDEPTH  = 8,
  parameter int BITQDEP = 3,
  parameter int CNTWDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tbl_ready,
  input  logic               in_update,
  input  logic [KYWIDTH-1:0] in_key,
  input  logic [DTWIDTH-1:0] in_din,
  input  logic               in_del,
  output logic               in_rdy,
  output logic               up_en,
  output logic [KYWIDTH-1:0] up_key,
  output logic [DTWIDTH-1:0] up_din,
  output logic               up_del,
  input  logic               up_bp,
  output logic [BITQDEP:0]   q_cnt,
  output logic [CNTWDTH-1:0] coal_cnt
);

  localparam logic [BITQDEP:0] QFULL = (BITQDEP+1)'(QDEPTH);

  // Queue storage. This is kept in registers because every entry is compared
  // against the incoming key in the same cycle.
  logic               valid_q [QDEPTH];
  logic [KYWIDTH-1:0] key_q   [QDEPTH];
  logic [DTWIDTH-1:0] din_q   [QDEPTH];
  logic               del_q   [QDEPTH];

  logic [BITQDEP-1:0] wr_ptr_q, rd_ptr_q;
  logic [BITQDEP:0]   cnt_q, cnt_d;
  logic               in_rdy_q;
  logic [CNTWDTH-1:0] coal_q;

  logic               up_en_q;
  logic [KYWIDTH-1:0] up_key_q;
  logic [DTWIDTH-1:0] up_din_q;
  logic               up_del_q;

  logic               accept, pop, hit, coalesce, push_new;
  logic [QDEPTH-1:0]  match_vec;
  logic [BITQDEP-1:0] match_idx;

  assign accept = in_update && in_rdy_q;
  assign pop    = (cnt_q != '0) && tbl_ready && !up_bp;

  // Per-entry key compare. A head that leaves this cycle must not absorb the
  // request; otherwise the new data would be lost.
  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_match
      assign match_vec[gi] = valid_q[gi] && (key_q[gi] == in_key) &&
                             !(pop && (rd_ptr_q == BITQDEP'(gi)));
    end
  endgenerate

  // Encode the single matching slot. At most one slot can match.
  always_comb begin
    match_idx = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (match_vec[i]) match_idx = BITQDEP'(i);
    end
  end

  assign hit      = |match_vec;
  assign coalesce = accept && hit;
  assign push_new = accept && !hit;

  // Occupancy next state. Only non-coalesced pushes grow the queue.
  always_comb begin
    cnt_d = cnt_q;
    if (push_new && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push_new) cnt_d = cnt_q - 1'b1;
  end

  // Entry storage: retire the head, append new entries, and merge coalesced data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        valid_q[i] <= 1'b0;
        key_q[i]   <= '0;
        din_q[i]   <= '0;
        del_q[i]   <= 1'b0;
      end
    end else begin
      if (pop) valid_q[rd_ptr_q] <= 1'b0;
      if (push_new) begin
        valid_q[wr_ptr_q] <= 1'b1;
        key_q[wr_ptr_q]   <= in_key;
        din_q[wr_ptr_q]   <= in_din;
        del_q[wr_ptr_q]   <= in_del;
      end
      if (coalesce) begin
        din_q[match_idx] <= in_din;
        del_q[match_idx] <= in_del;
      end
    end
  end

  // Pointers, occupancy, ready flag and the saturating coalesce counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      in_rdy_q <= 1'b0;
      coal_q   <= '0;
    end else begin
      if (push_new) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q    <= cnt_d;
      in_rdy_q <= (cnt_d < QFULL);
      if (coalesce && (coal_q != '1)) coal_q <= coal_q + 1'b1;
    end
  end

  // Issue register: the popped head is presented to the table in the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_en_q  <= 1'b0;
      up_key_q <= '0;
      up_din_q <= '0;
      up_del_q <= 1'b0;
    end else begin
      up_en_q <= pop;
      if (pop) begin
        up_key_q <= key_q[rd_ptr_q];
        up_din_q <= din_q[rd_ptr_q];
        up_del_q <= del_q[rd_ptr_q];
      end
    end
  end

  assign in_rdy   = in_rdy_q;
  assign up_en    = up_en_q;
  assign up_key   = up_key_q;
  assign up_din   = up_din_q;
  assign up_del   = up_del_q;
  assign q_cnt    = cnt_q;
  assign coal_cnt = coal_q;

endmodule

// File: tb/tb_algo_hash_update_queue.sv
// Bench for algo_hash_update_queue: vector table, directed corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_algo_hash_update_queue;
  localparam int KW = 32;
  localparam int DW = 32;
  localparam int QD = 8;
  localparam int BQ = 3;
  localparam int CW = 4;   // small counter width so that saturation is reached

  logic          clk = 1'b0;
  logic          rst;
  logic          tbl_ready, in_update, in_del, up_bp;
  logic [KW-1:0] in_key;
  logic [DW-1:0] in_din;
  logic          in_rdy, up_en, up_del;
  logic [KW-1:0] up_key;
  logic [DW-1:0] up_din;
  logic [BQ:0]   q_cnt;
  logic [CW-1:0] coal_cnt;

  always #5 clk = ~clk;

  algo_hash_update_queue #(
    .KYWIDTH(KW), .DTWIDTH(DW), .QDEPTH(QD), .BITQDEP(BQ), .CNTWDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .tbl_ready(tbl_ready), .in_update(in_update),
    .in_key(in_key), .in_din(in_din), .in_del(in_del), .in_rdy(in_rdy),
    .up_en(up_en), .up_key(up_key), .up_din(up_din), .up_del(up_del),
    .up_bp(up_bp), .q_cnt(q_cnt), .coal_cnt(coal_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered list of pending updates.
  typedef struct { logic [KW-1:0] key; logic [DW-1:0] din; logic del; } ent_t;
  ent_t          mq[$];
  int unsigned   m_coal;
  bit            m_started;
  logic          m_en, m_del;
  logic [KW-1:0] m_key;
  logic [DW-1:0] m_din;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_coal = 0; m_started = 0;
    m_en = 0; m_key = '0; m_din = '0; m_del = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit rdy, pop;
    rdy = m_started && (mq.size() < QD);
    pop = (mq.size() > 0) && tbl_ready && !up_bp;
    if (pop) begin
      ent_t h;
      h = mq.pop_front();
      m_en = 1; m_key = h.key; m_din = h.din; m_del = h.del;
    end else begin
      m_en = 0;
    end
    if (in_update && rdy) begin
      int hit;
      hit = -1;
      foreach (mq[i]) if (mq[i].key == in_key) hit = i;
      if (hit >= 0) begin
        mq[hit].din = in_din;
        mq[hit].del = in_del;
        if (m_coal < (2**CW - 1)) m_coal++;
      end else begin
        mq.push_back('{key: in_key, din: in_din, del: in_del});
      end
    end
    m_started = 1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".up_en"},    up_en,    m_en);
    chk({tag, ".up_key"},   up_key,   m_key);
    chk({tag, ".up_din"},   up_din,   m_din);
    chk({tag, ".up_del"},   up_del,   m_del);
    chk({tag, ".q_cnt"},    q_cnt,    mq.size());
    chk({tag, ".in_rdy"},   in_rdy,   (mq.size() < QD));
    chk({tag, ".coal_cnt"}, coal_cnt, m_coal);
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic step(input string tag, input logic upd, input logic [KW-1:0] key,
                      input logic [DW-1:0] din, input logic del,
                      input logic bp, input logic tr);
    in_update = upd; in_key = key; in_din = din; in_del = del;
    up_bp = bp; tbl_ready = tr;
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, '0, '0, 0, 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".up_en"},    up_en,    0);
    chk({tag, ".up_key"},   up_key,   0);
    chk({tag, ".up_din"},   up_din,   0);
    chk({tag, ".up_del"},   up_del,   0);
    chk({tag, ".q_cnt"},    q_cnt,    0);
    chk({tag, ".in_rdy"},   in_rdy,   0);
    chk({tag, ".coal_cnt"}, coal_cnt, 0);
  endtask

  typedef struct {
    logic upd; logic [KW-1:0] key; logic [DW-1:0] din; logic del; logic bp; logic tr;
    logic e_en; logic [KW-1:0] e_key; logic [DW-1:0] e_din; logic e_del;
    int e_cnt; int e_coal;
  } vec_t;

  vec_t tv[14];

  initial begin
    // upd key din del bp tr | en key din del cnt coal
    tv[0]  = '{1, 'hA, 'h11, 0, 1, 1,  0, 'h0, 'h00, 0, 1, 0};
    tv[1]  = '{1, 'hB, 'h22, 0, 1, 1,  0, 'h0, 'h00, 0, 2, 0};
    tv[2]  = '{1, 'hA, 'h33, 1, 1, 1,  0, 'h0, 'h00, 0, 2, 1};
    tv[3]  = '{0, 'h0, 'h00, 0, 0, 1,  1, 'hA, 'h33, 1, 1, 1};
    tv[4]  = '{0, 'h0, 'h00, 0, 0, 1,  1, 'hB, 'h22, 0, 0, 1};
    tv[5]  = '{0, 'h0, 'h00, 0, 0, 1,  0, 'hB, 'h22, 0, 0, 1};
    tv[6]  = '{1, 'hC, 'h44, 0, 0, 1,  0, 'hB, 'h22, 0, 1, 1};
    tv[7]  = '{0, 'h0, 'h00, 0, 0, 1,  1, 'hC, 'h44, 0, 0, 1};
    tv[8]  = '{1, 'h5, 'h55, 0, 0, 1,  0, 'hC, 'h44, 0, 1, 1};
    tv[9]  = '{1, 'h5, 'h66, 0, 0, 1,  1, 'h5, 'h55, 0, 1, 1};
    tv[10] = '{0, 'h0, 'h00, 0, 0, 1,  1, 'h5, 'h66, 0, 0, 1};
    tv[11] = '{1, 'h7, 'h77, 0, 0, 0,  0, 'h5, 'h66, 0, 1, 1};
    tv[12] = '{1, 'h7, 'h88, 0, 0, 0,  0, 'h5, 'h66, 0, 1, 2};
    tv[13] = '{0, 'h0, 'h00, 0, 0, 1,  1, 'h7, 'h88, 0, 0, 2};

    rst = 1'b0; tbl_ready = 0; in_update = 0; in_key = '0; in_din = '0;
    in_del = 0; up_bp = 0;
    model_reset();

    // Reset state and the first ready cycle after release.
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release.in_rdy_low", in_rdy, 0);
    idle("first_cycle", 1);

    // Vector table: coalesce, issue latency, head-pop key clash, tbl_ready low.
    for (int i = 0; i < 14; i++) begin
      step($sformatf("vec%0d", i), tv[i].upd, tv[i].key, tv[i].din, tv[i].del,
           tv[i].bp, tv[i].tr);
      chk($sformatf("vec%0d.t_en", i),   up_en,    tv[i].e_en);
      chk($sformatf("vec%0d.t_key", i),  up_key,   tv[i].e_key);
      chk($sformatf("vec%0d.t_din", i),  up_din,   tv[i].e_din);
      chk($sformatf("vec%0d.t_del", i),  up_del,   tv[i].e_del);
      chk($sformatf("vec%0d.t_cnt", i),  q_cnt,    tv[i].e_cnt);
      chk($sformatf("vec%0d.t_coal", i), coal_cnt, tv[i].e_coal);
      chk($sformatf("vec%0d.t_rdy", i),  in_rdy,   1);
    end

    // Simple in-order stream of three keys.
    for (int k = 1; k <= 3; k++) step("stream", 1, k, 'h100 + k, 0, 0, 1);
    idle("stream_drain", 4);

    // Fill to full under backpressure; the 9th request is refused, then held
    // until the first pop frees a slot.
    for (int k = 0; k < QD; k++) step("fill", 1, 'h20 + k, 'h200 + k, 0, 1, 1);
    chk("fill.full_cnt", q_cnt, QD);
    chk("fill.full_rdy", in_rdy, 0);
    step("fill_held", 1, 'h99, 'h999, 1, 1, 1);
    step("fill_release0", 1, 'h99, 'h999, 1, 0, 1);
    step("fill_release1", 1, 'h99, 'h999, 1, 0, 1);
    idle("fill_drain", QD + 2);

    // Asynchronous reset with entries queued and an issue in flight.
    for (int k = 0; k < 4; k++) step("pre_rst", 1, 'h40 + k, 'h400 + k, 0, 1, 1);
    step("pre_rst_pop", 0, '0, '0, 0, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle("post_rst", 6);

    // Random traffic over a narrow key space, alternating light and heavy backpressure.
    for (int i = 0; i < 2000; i++) begin
      logic bpv;
      bpv = (((i / 200) % 2) == 1) ? (($urandom % 8) < 6) : (($urandom % 8) == 0);
      step("rand", ($urandom % 3) != 0, $urandom % 6, $urandom, $urandom % 2,
           bpv, ($urandom % 5) != 0);
    end
    idle("rand_drain", QD + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
